ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- On-chip memory responder for the RAM side of the core's cache refill/writeback port.
- Serves 128-bit line transfers as bursts of BUS_WIDTH-bit beats: zero-latency (combinational) read, posedge write.
- Tracks burst structure and flags protocol violations.
- Used as the default memory in the SoC top and as the reference slave in core benches.

Parameters:
BUS_WIDTH, 128, beat width in bits; legal values 16/32/64/128.
DATA_WIDTH, 8, addressable unit in bits; legal values 8/16/32/64, must be <= BUS_WIDTH.
MEM_ROWS, 1024, number of BUS_WIDTH-bit storage rows.
INIT_FILE, "", hex preload file for $readmemh; no preload when empty.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
write_enable  in  1  write beat request
read_enable  in  1  read beat request
address  in  32  address in DATA_WIDTH units, beat-aligned
din  in  BUS_WIDTH  write data; stable at posedge
dout  out  BUS_WIDTH  read data; combinational from address
burst_done  out  1  one-cycle pulse after the last beat of a burst
error  out  1  sticky protocol error
error_code  out  2  first error: 0 none, 1 misaligned/non-sequential, 2 abort/direction change, 3 out of range or read+write together
error_clear  in  1  synchronous clear of error/error_code
read_bursts  out  16  completed read bursts, wraps
write_bursts  out  16  completed write bursts, wraps

Behaviour:
- Derived constants: STEP = BUS_WIDTH/DATA_WIDTH; BEATS = 128/BUS_WIDTH; LINE = 128/DATA_WIDTH; row = address/STEP.
- Reset (async, reset=0):
  - Outputs and state: state=IDLE, beat=0, burst_done=0, error=0, error_code=0, counters=0.
  - Memory array is not cleared.
  - dout still follows address combinationally.
- Read:
  - dout = mem[row] whenever row < MEM_ROWS, else 0.
  - Same-cycle data; no enable needed.
- Write:
  - At posedge, if write_enable && !read_enable && row < MEM_ROWS && no beat error this cycle, mem[row] <= din.
  - A write to a row is visible on dout in the next cycle.
- Beat FSM, states IDLE, RD, WR; beat counter 0..BEATS-1:
  - IDLE plus an enable:
    - Enter RD or WR with beat=1.
    - First beat must satisfy address % LINE == 0; otherwise code 1.
    - Stay in IDLE when BEATS=1, see BEATS=1 rule.
  - RD/WR, same enable held:
    - Each cycle is one beat.
    - Address must equal prev_address+STEP; otherwise code 1.
    - beat increments.
  - Beat BEATS-1 accepted:
    - Next cycle burst_done=1 and the matching counter increments.
    - beat=0, same state.
    - Back-to-back bursts are legal: the next beat is a new first beat and needs line alignment.
  - Enable dropped with beat != 0: code 2, go to IDLE.
  - Enable dropped with beat == 0: go to IDLE, no error.
  - Opposite enable mid-burst: code 2; restart the burst in the new direction as a first beat.
  - BEATS=1: every enabled cycle is a complete burst; burst_done the next cycle; only the alignment check applies.
- Errors:
  - error is sticky; error_code latches the first error only.
  - read_enable && write_enable together: code 3, write suppressed, FSM state and beat unchanged.
  - Out-of-range row with an enable asserted: code 3, write suppressed; beat still counts.
  - error_clear takes priority over a new error in the same cycle.
- Counters: 16-bit, wrap from 0xFFFF to 0.
- Reset mid-burst: FSM returns to IDLE immediately; a partial write keeps the rows already written.

Test Plan:
1. BUS_WIDTH=32, DATA_WIDTH=8. Write 4 beats at 0x100/0x104/0x108/0x10C with din 0x11111111..0x44444444, then read them back -> dout matches each beat; burst_done pulses once per burst; write_bursts=1, read_bursts=1; error=0.
2. BUS_WIDTH=32. Read burst starting at 0x104 -> error=1, error_code=1 from the first beat; data still returned. Assert error_clear -> error=0, error_code=0.
3. BUS_WIDTH=32. Drop read_enable after 2 beats (0x200, 0x204) -> error_code=2, FSM IDLE, no burst_done, read_bursts unchanged.
4. BUS_WIDTH=32. Assert read_enable and write_enable together at 0x300 with din=0xDEADBEEF -> error_code=3; mem row 0xC0 unchanged (preloaded 0).
5. BUS_WIDTH=32. Hold read_enable for 8 beats 0x400..0x41C -> two burst_done pulses, read_bursts=2, no error. Pull reset low on beat 3 of a third burst -> all outputs 0 asynchronously.
6. BUS_WIDTH=128. Write at 0x0, then at 0x10 -> burst_done each cycle, write_bursts=2. Address 0x8 -> error_code=1. Row 1024 (address 0x4000) -> dout=0, error_code=3 after clear.

Source files
------------

// File: rtl/ram_responder.sv
// Line-refill memory responder: combinational read, posedge write, beat-level burst
// tracking with a sticky first-error code and per-direction completed-burst counters.
module ram_responder #(
  parameter int    BUS_WIDTH  = 128,
  parameter int    DATA_WIDTH = 8,
  parameter int    MEM_ROWS   = 1024,
  parameter string INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic                 read_enable,
  input  logic [31:0]          address,
  input  logic [BUS_WIDTH-1:0] din,
  output logic [BUS_WIDTH-1:0] dout,
  output logic                 burst_done,
  output logic                 error,
  output logic [1:0]           error_code,
  input  logic                 error_clear,
  output logic [15:0]          read_bursts,
  output logic [15:0]          write_bursts
);

  localparam int STEP    = BUS_WIDTH / DATA_WIDTH;
  localparam int BEATS   = 128 / BUS_WIDTH;
  localparam int LINE    = 128 / DATA_WIDTH;
  localparam int STEP_SH = $clog2(STEP);
  localparam int ROW_W   = (MEM_ROWS > 1) ? $clog2(MEM_ROWS) : 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [31:0]       LINE_MASK = 32'(LINE - 1);
  localparam logic [31:0]       STEP_ADDR = 32'(STEP);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t              r_state, w_state_nxt, w_dir;
  logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
  logic [31:0]         r_prev_addr;
  logic                r_burst_done, r_error;
  logic [1:0]          r_error_code, w_code;
  logic [15:0]         r_read_bursts, r_write_bursts;
  logic                w_err, w_last, w_first, w_both, w_req, w_in_range, w_we;
  logic [31:0]         w_row;
  logic [BUS_WIDTH-1:0] r_mem [MEM_ROWS];

  assign w_row      = address >> STEP_SH;
  assign w_in_range = (w_row < 32'(MEM_ROWS));
  assign w_both     = read_enable && write_enable;
  assign w_req      = read_enable || write_enable;
  assign w_dir      = write_enable ? WR : RD;
  assign dout       = w_in_range ? r_mem[w_row[ROW_W-1:0]] : '0;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_err       = 1'b0;
    w_code      = 2'd0;
    w_last      = 1'b0;
    w_first     = 1'b0;
    if (w_both) begin
      w_err  = 1'b1;
      w_code = 2'd3;
    end else if (w_req) begin
      w_first = (r_state == IDLE) || (r_beat == '0) || (r_state != w_dir);
      // Codes are applied low to high so the most severe one wins within a cycle.
      if (w_first ? ((address & LINE_MASK) != '0) : (address != r_prev_addr + STEP_ADDR)) begin
        w_err  = 1'b1;
        w_code = 2'd1;
      end
      if (r_state != IDLE && r_state != w_dir && r_beat != '0) begin
        w_err  = 1'b1;
        w_code = 2'd2;
      end
      if (!w_in_range) begin
        w_err  = 1'b1;
        w_code = 2'd3;
      end
      if (w_first) begin
        if (BEATS == 1) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
          w_beat_nxt  = '0;
        end else begin
          w_state_nxt = w_dir;
          w_beat_nxt  = BEAT_W'(1);
        end
      end else if (r_beat == LAST_BEAT) begin
        w_last     = 1'b1;
        w_beat_nxt = '0;
      end else begin
        w_beat_nxt = r_beat + BEAT_W'(1);
      end
    end else begin
      if (r_state != IDLE && r_beat != '0) begin
        w_err  = 1'b1;
        w_code = 2'd2;
      end
      w_state_nxt = IDLE;
      w_beat_nxt  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_beat         <= '0;
      r_prev_addr    <= '0;
      r_burst_done   <= 1'b0;
      r_error        <= 1'b0;
      r_error_code   <= 2'd0;
      r_read_bursts  <= '0;
      r_write_bursts <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_burst_done <= w_last;
      if (w_req && !w_both) r_prev_addr <= address;
      if (w_last) begin
        if (w_dir == WR) r_write_bursts <= r_write_bursts + 16'd1;
        else             r_read_bursts  <= r_read_bursts + 16'd1;
      end
      if (error_clear) begin
        r_error      <= 1'b0;
        r_error_code <= 2'd0;
      end else if (w_err && !r_error) begin
        r_error      <= 1'b1;
        r_error_code <= w_code;
      end
    end
  end

  assign w_we = write_enable && !read_enable && !w_err;

  // NOTE: the storage array has no reset; contents survive reset and only writes change them.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_row[ROW_W-1:0]] <= din;
  end

  assign burst_done   = r_burst_done;
  assign error        = r_error;
  assign error_code   = r_error_code;
  assign read_bursts  = r_read_bursts;
  assign write_bursts = r_write_bursts;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a 32-bit-beat instance for burst/error behaviour
// and a 128-bit-beat instance for single-beat lines and range checks.
module tb_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst32, we32, re32, clr32, done32, err32;
  logic [31:0] a32, d32, q32;
  logic [1:0]  code32;
  logic [15:0] rb32, wb32;

  logic         rst128, we128, re128, clr128, done128, err128;
  logic [31:0]  a128;
  logic [127:0] d128, q128;
  logic [1:0]   code128;
  logic [15:0]  rb128, wb128;

  ram_responder #(.BUS_WIDTH(32), .DATA_WIDTH(8), .MEM_ROWS(1024), .INIT_FILE("")) u_dut32 (
    .clk(clk), .reset(rst32), .write_enable(we32), .read_enable(re32), .address(a32),
    .din(d32), .dout(q32), .burst_done(done32), .error(err32), .error_code(code32),
    .error_clear(clr32), .read_bursts(rb32), .write_bursts(wb32));

  ram_responder #(.BUS_WIDTH(128), .DATA_WIDTH(8), .MEM_ROWS(1024), .INIT_FILE("")) u_dut128 (
    .clk(clk), .reset(rst128), .write_enable(we128), .read_enable(re128), .address(a128),
    .din(d128), .dout(q128), .burst_done(done128), .error(err128), .error_code(code128),
    .error_clear(clr128), .read_bursts(rb128), .write_bursts(wb128));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] din);
    we32 = we; re32 = re; a32 = addr; d32 = din;
    #1;
  endtask

  task automatic drive128(input logic we, input logic re, input logic [31:0] addr,
                          input logic [127:0] din);
    we128 = we; re128 = re; a128 = addr; d128 = din;
    #1;
  endtask

  task automatic clear32();
    drive32(1'b0, 1'b0, 32'h0, 32'h0);
    clr32 = 1'b1;
    tick();
    clr32 = 1'b0;
    check("clear32_err", err32, 0);
    check("clear32_code", code32, 0);
  endtask

  initial begin
    rst32 = 1'b0; we32 = 1'b0; re32 = 1'b0; clr32 = 1'b0; a32 = '0; d32 = '0;
    rst128 = 1'b0; we128 = 1'b0; re128 = 1'b0; clr128 = 1'b0; a128 = '0; d128 = '0;
    #12;
    check("rst_done", done32, 0);
    check("rst_err", err32, 0);
    check("rst_code", code32, 0);
    check("rst_rb", rb32, 0);
    check("rst_wb", wb32, 0);
    check("rst_err128", err128, 0);
    rst32 = 1'b1; rst128 = 1'b1;
    tick();

    // Four-beat write line, then read it back back-to-back.
    for (int i = 0; i < 4; i++) begin
      drive32(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h11111111 * 32'(i + 1));
      tick();
      check("wr_done", done32, (i == 3));
    end
    check("wr_wb", wb32, 1);
    for (int i = 0; i < 4; i++) begin
      drive32(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h0);
      check("rd_dout", q32, 32'h11111111 * 32'(i + 1));
      tick();
      check("rd_done", done32, (i == 3));
    end
    drive32(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("t1_rb", rb32, 1);
    check("t1_wb", wb32, 1);
    check("t1_err", err32, 0);

    // Misaligned first beat still returns data; later abort does not overwrite the code.
    drive32(1'b0, 1'b1, 32'h104, 32'h0);
    check("mis_dout", q32, 32'h22222222);
    tick();
    check("mis_err", err32, 1);
    check("mis_code", code32, 1);
    drive32(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("sticky_code", code32, 1);
    clear32();

    // Abort after two beats.
    drive32(1'b0, 1'b1, 32'h200, 32'h0);
    tick();
    drive32(1'b0, 1'b1, 32'h204, 32'h0);
    tick();
    drive32(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("abort_code", code32, 2);
    check("abort_done", done32, 0);
    check("abort_rb", rb32, 1);
    clear32();

    // Zero row 0xC0, then read+write together must not write it.
    for (int i = 0; i < 4; i++) begin
      drive32(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0);
      tick();
    end
    check("zero_wb", wb32, 2);
    drive32(1'b1, 1'b1, 32'h300, 32'hDEADBEEF);
    tick();
    check("rw_err", err32, 1);
    check("rw_code", code32, 3);
    check("rw_done", done32, 0);
    drive32(1'b0, 1'b0, 32'h300, 32'h0);
    check("rw_mem", q32, 32'h0);
    tick();
    check("rw_wb", wb32, 2);
    clear32();

    // Two back-to-back read lines, then reset during the third.
    for (int i = 0; i < 8; i++) begin
      drive32(1'b0, 1'b1, 32'h400 + 32'(4 * i), 32'h0);
      tick();
      check("b2b_done", done32, (i == 3 || i == 7));
    end
    check("b2b_rb", rb32, 3);
    check("b2b_err", err32, 0);
    for (int i = 0; i < 2; i++) begin
      drive32(1'b0, 1'b1, 32'h420 + 32'(4 * i), 32'h0);
      tick();
    end
    drive32(1'b0, 1'b1, 32'h428, 32'h0);
    rst32 = 1'b0;
    #1;
    check("arst_rb", rb32, 0);
    check("arst_wb", wb32, 0);
    check("arst_done", done32, 0);
    check("arst_err", err32, 0);
    drive32(1'b0, 1'b0, 32'h100, 32'h0);
    check("arst_mem_kept", q32, 32'h11111111);
    rst32 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive32(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'h0);
      tick();
    end
    drive32(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("post_rst_rb", rb32, 1);
    check("post_rst_err", err32, 0);

    // 128-bit beats: every enabled cycle is a whole line.
    drive128(1'b1, 1'b0, 32'h0, 128'hA5A5_0001);
    tick();
    check("w128_done0", done128, 1);
    check("w128_wb1", wb128, 1);
    drive128(1'b1, 1'b0, 32'h10, 128'hC3C3_0002);
    tick();
    check("w128_done1", done128, 1);
    check("w128_wb2", wb128, 2);
    drive128(1'b0, 1'b0, 32'h0, 128'h0);
    check("r128_row0", q128, 128'hA5A5_0001);
    tick();
    check("w128_done_off", done128, 0);
    drive128(1'b0, 1'b0, 32'h10, 128'h0);
    check("r128_row1", q128, 128'hC3C3_0002);
    drive128(1'b0, 1'b1, 32'h8, 128'h0);
    tick();
    check("mis128_code", code128, 1);
    check("mis128_rb", rb128, 1);
    drive128(1'b0, 1'b0, 32'h0, 128'h0);
    clr128 = 1'b1;
    tick();
    clr128 = 1'b0;
    check("clr128_err", err128, 0);
    // Clear wins over a fresh error in the same cycle.
    drive128(1'b0, 1'b1, 32'h8, 128'h0);
    clr128 = 1'b1;
    tick();
    clr128 = 1'b0;
    check("clr_prio_err", err128, 0);
    drive128(1'b0, 1'b1, 32'h4000, 128'h0);
    check("oor_dout", q128, 128'h0);
    tick();
    check("oor_code", code128, 3);
    check("oor_rb", rb128, 3);
    drive128(1'b0, 1'b0, 32'h0, 128'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
